mem_burst_seq: RTL and testbench
================================

Name: mem_burst_seq

Overview:
- Upstream command sequencer for the 32x8 single-port scratch memory (1-cycle registered read, write-before-read-same-cycle not guaranteed, rdata reset to 0).
- Turns one burst command (start address, length, direction) into per-cycle memory address and write strobes.
- Accepts write bytes on a valid/ready stream and returns read bytes on a valid/ready stream, with backpressure absorbed by a 2-entry skid FIFO.

Parameters:
- ADDR_W, 5, memory address width; the burst address wraps modulo 2^ADDR_W.
- DATA_W, 8, data byte width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  ADDR_W  start address.
- cmd_len  in  ADDR_W  beats minus 1; the range 0..31 gives 1..32 beats.
- wr_valid  in  1  write byte offered.
- wr_ready  out  1  high in WRITE.
- wr_data  in  DATA_W  write byte.
- rd_valid  out  1  read FIFO non-empty.
- rd_ready  in  1  consumer accepts.
- rd_data  out  DATA_W  FIFO head.
- mem_addr  out  ADDR_W  memory address.
- mem_wr  out  1  memory write strobe.
- mem_wdata  out  DATA_W  memory write data, equal to wr_data.
- mem_rdata  in  DATA_W  memory registered read data.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at burst completion.

Behaviour:
- Reset: state = IDLE, addr_q = 0, beats_left = 0, rd_inflight = 0, FIFO empty.
  - Outputs after reset: cmd_ready = 1, wr_ready = 0, rd_valid = 0, mem_wr = 0, mem_addr = 0, busy = 0, done = 0.
  - Reset mid-burst aborts the burst; FIFO contents are discarded and no done pulse is issued.
- FSM states: IDLE, WRITE, READ.
- IDLE:
  - A command is accepted when cmd_valid && cmd_ready.
  - On acceptance: addr_q <= cmd_addr, beats_left <= cmd_len + 1 (ADDR_W+1 bits), next state = WRITE if cmd_write, else READ.
- WRITE:
  - wr_ready = 1. mem_wr = wr_valid (combinational). mem_addr = addr_q.
  - On each accepted beat: addr_q increments with wrap (31 -> 0) and beats_left decrements.
  - After the last beat (beats_left == 1 and accepted): next state = IDLE, done = 1 in the following cycle (registered).
- READ:
  - A read is issued when beats_left != 0 and (fifo_count + rd_inflight) < 2.
  - Issue: mem_addr = addr_q, rd_inflight <= 1, addr_q increments with wrap, beats_left decrements.
  - mem_wr = 0 throughout READ.
  - The cycle after an issue, mem_rdata is pushed into the FIFO and rd_inflight clears.
  - Exit to IDLE when beats_left == 0 and rd_inflight == 0; done pulses in that same transition cycle (registered).
  - The FIFO may still hold data after done; the consumer drains it independently.
- mem_addr in IDLE holds addr_q.
- Read FIFO (2 entries):
  - Push and pop may occur in the same cycle.
  - A push into a full FIFO is impossible by the credit rule; the verifier asserts this never happens.
  - rd_data is stable while rd_valid && !rd_ready.
- Throughput: 1 write beat per cycle. 1 read per cycle when rd_ready is held high; first rd_valid appears 2 cycles after the command is accepted.
- A new command is accepted in the cycle after done, even if the FIFO is non-empty.
- Commands presented while busy are ignored: cmd_ready = 0 and command fields are not sampled.

Optional Feature:
- MEM_BURST_CSUM_EN defined:
  - Adds output csum (DATA_W): the running XOR of every written byte (WRITE) or every byte pushed into the FIFO (READ) for the current burst.
  - csum clears on command acceptance, is valid when done pulses, and holds until the next command. Reset value 0.
- Not defined: no csum port and no checksum logic.

Decomposition:
- Package mem_burst_pkg:
  - state enum {ST_IDLE, ST_WRITE, ST_READ}.
  - Constants MB_ADDR_W = 5, MB_DATA_W = 8, MB_FIFO_DEPTH = 2.
- Sub-module mem_burst_rd_fifo: 2-entry synchronous FIFO exposing push, pop, count, and head data. Same clk/rst.

Test Plan:
- Write burst: cmd addr = 3, len = 3, write = 1; wr_data 0xA0..0xA3 with wr_valid held high -> mem_wr high for 4 consecutive cycles with mem_addr 3, 4, 5, 6; done 1 cycle after the 4th beat; busy low afterwards.
- Wrap-around write: addr = 30, len = 3 -> mem_addr sequence 30, 31, 0, 1. A subsequent read burst addr = 30, len = 3 with rd_ready = 1 -> rd_data returns the same 4 bytes in order; first rd_valid 2 cycles after command acceptance.
- Read backpressure: 8-beat read with rd_ready low for cycles 2..6 -> at most 2 issues outstanding, no FIFO overflow, rd_data held stable while stalled, all 8 bytes delivered in order, done exactly once.
- Write stall: wr_valid toggles 1, 0, 1, 0 over a 2-beat burst -> mem_wr mirrors wr_valid; only valid beats advance the address; done after the 2nd accepted beat.
- Reset mid-read: assert rst during beat 3 of a 16-beat read -> next cycle busy = 0, rd_valid = 0, cmd_ready = 1, no done pulse; a fresh 1-beat read (len = 0) then completes normally.
- MEM_BURST_CSUM_EN: write 0x12, 0x34, 0x56 -> csum = 0x70 at done. Read the same 3 locations back -> csum = 0x70.

Source files
------------

// File: rtl/mem_burst_pkg.sv
// Shared types and sizing constants for the burst sequencer.
package mem_burst_pkg;

  localparam int MB_ADDR_W     = 5;
  localparam int MB_DATA_W     = 8;
  localparam int MB_FIFO_DEPTH = 2;
  localparam int MB_FIFO_PTR_W = $clog2(MB_FIFO_DEPTH);
  localparam int MB_FIFO_CNT_W = $clog2(MB_FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ
  } state_t;

endpackage

// File: rtl/mem_burst_seq_if.sv
// Command, write-stream, read-stream and memory-side signals of the burst sequencer.
interface mem_burst_seq_if #(
  parameter int ADDR_W = mem_burst_pkg::MB_ADDR_W,
  parameter int DATA_W = mem_burst_pkg::MB_DATA_W
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W-1:0] cmd_len;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Sequencer side
  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len,
    input  wr_valid, wr_data, rd_ready, mem_rdata,
    output cmd_ready, wr_ready, rd_valid, rd_data,
    output mem_addr, mem_wr, mem_wdata
  );

  // Environment side (command source, streams, memory)
  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_len,
    output wr_valid, wr_data, rd_ready, mem_rdata,
    input  cmd_ready, wr_ready, rd_valid, rd_data,
    input  mem_addr, mem_wr, mem_wdata
  );

endinterface

// File: rtl/mem_burst_rd_fifo.sv
// Small read-return skid FIFO; push and pop may coincide, pop on empty is ignored.
module mem_burst_rd_fifo
  import mem_burst_pkg::*;
#(
  parameter int DATA_W = MB_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [DATA_W-1:0]        i_push_data,
  input  logic                     i_pop,
  output logic [MB_FIFO_CNT_W-1:0] o_count,
  output logic                     o_valid,
  output logic [DATA_W-1:0]        o_head
);

  logic [MB_FIFO_DEPTH-1:0][DATA_W-1:0] w_entries;
  logic [MB_FIFO_PTR_W-1:0]             r_wptr;
  logic [MB_FIFO_PTR_W-1:0]             r_rptr;
  logic [MB_FIFO_CNT_W-1:0]             r_count;
  logic                                 w_pop;

  assign w_pop = i_pop && (r_count != '0);

  genvar gi;
  generate
    for (gi = 0; gi < MB_FIFO_DEPTH; gi++) begin : g_entry
      logic [DATA_W-1:0] r_entry;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_entry <= '0;
        end else if (i_push && (r_wptr == MB_FIFO_PTR_W'(gi))) begin
          r_entry <= i_push_data;
        end
      end
      assign w_entries[gi] = r_entry;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count = r_count;
  assign o_valid = (r_count != '0);
  assign o_head  = w_entries[r_rptr];

endmodule

// File: rtl/mem_burst_seq.sv
// Burst command sequencer for a single-port scratch memory with registered read.
// Optional running XOR checksum output when MEM_BURST_CSUM_EN is defined.
module mem_burst_seq
  import mem_burst_pkg::*;
#(
  parameter int ADDR_W = MB_ADDR_W,
  parameter int DATA_W = MB_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  mem_burst_seq_if.slave    bus,
  output logic              busy,
  output logic              done
`ifdef MEM_BURST_CSUM_EN
  ,
  output logic [DATA_W-1:0] csum
`endif
);

  localparam int CRD_W = MB_FIFO_CNT_W + 1;

  state_t                   r_state;
  logic [ADDR_W-1:0]        r_addr;
  logic [ADDR_W:0]          r_beats;
  logic                     r_inflight;
  logic                     r_done;

  logic                     w_cmd_acc;
  logic                     w_wr_acc;
  logic                     w_issue;
  logic                     w_push;
  logic                     w_pop;
  logic [MB_FIFO_CNT_W-1:0] w_fifo_count;
  logic [CRD_W-1:0]         w_credit;
  logic [CRD_W-1:0]         w_credit_lim;

  assign w_cmd_acc = bus.cmd_valid && (r_state == ST_IDLE);
  assign w_wr_acc  = (r_state == ST_WRITE) && bus.wr_valid;
  assign w_push    = r_inflight;
  assign w_pop     = bus.rd_valid && bus.rd_ready;

  // A same-cycle pop frees a slot, so counting it keeps one read per cycle
  // under continuous rd_ready without ever pushing into a full FIFO.
  assign w_credit     = {1'b0, w_fifo_count} + CRD_W'(r_inflight);
  assign w_credit_lim = CRD_W'(MB_FIFO_DEPTH) + CRD_W'(w_pop);
  assign w_issue      = (r_state == ST_READ) && (r_beats != '0) && (w_credit < w_credit_lim);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_beats    <= '0;
      r_inflight <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_inflight <= w_issue;
      case (r_state)
        ST_IDLE: begin
          if (w_cmd_acc) begin
            r_addr  <= bus.cmd_addr;
            r_beats <= {1'b0, bus.cmd_len} + (ADDR_W + 1)'(1);
            r_state <= bus.cmd_write ? ST_WRITE : ST_READ;
          end
        end
        ST_WRITE: begin
          if (w_wr_acc) begin
            r_addr  <= r_addr + 1'b1;
            r_beats <= r_beats - 1'b1;
            if (r_beats == (ADDR_W + 1)'(1)) begin
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
            end
          end
        end
        ST_READ: begin
          if (w_issue) begin
            r_addr  <= r_addr + 1'b1;
            r_beats <= r_beats - 1'b1;
          end else if ((r_beats == '0) && !r_inflight) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  mem_burst_rd_fifo #(
    .DATA_W(DATA_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_push_data(bus.mem_rdata),
    .i_pop      (bus.rd_ready),
    .o_count    (w_fifo_count),
    .o_valid    (bus.rd_valid),
    .o_head     (bus.rd_data)
  );

  assign bus.cmd_ready = (r_state == ST_IDLE);
  assign bus.wr_ready  = (r_state == ST_WRITE);
  assign bus.mem_wr    = w_wr_acc;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = bus.wr_data;
  assign busy          = (r_state != ST_IDLE);
  assign done          = r_done;

`ifdef MEM_BURST_CSUM_EN
  logic [DATA_W-1:0] r_csum;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_csum <= '0;
    end else if (w_cmd_acc) begin
      r_csum <= '0;
    end else if (w_wr_acc) begin
      r_csum <= r_csum ^ bus.wr_data;
    end else if (w_push) begin
      r_csum <= r_csum ^ bus.mem_rdata;
    end
  end

  assign csum = r_csum;
`endif

endmodule

// File: tb/tb_mem_burst_seq.sv
// Scoreboard bench for mem_burst_seq with a behavioural 32x8 registered-read memory.
module tb_mem_burst_seq;

  logic clk;
  logic rst;
  logic busy;
  logic done;
`ifdef MEM_BURST_CSUM_EN
  logic [7:0] csum;
`endif

  mem_burst_seq_if bus ();

  mem_burst_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .busy(busy),
    .done(done)
`ifdef MEM_BURST_CSUM_EN
    ,
    .csum(csum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int ovf_cnt  = 0;

  logic [7:0]  mem_arr [32];
  logic [7:0]  ref_mem [32];
  logic [7:0]  wbuf    [32];
  logic        mem_init;
  logic [12:0] wq [$];
  logic [7:0]  rq [$];
  logic        prev_stall;
  logic [7:0]  prev_data;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Memory model: read returns the pre-write contents of the addressed word.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 32; i++) mem_arr[i] <= 8'(i * 37 + 11);
    end else if (bus.mem_wr) begin
      mem_arr[bus.mem_addr] <= bus.mem_wdata;
    end
    if (rst) bus.mem_rdata <= '0;
    else     bus.mem_rdata <= mem_arr[bus.mem_addr];
  end

  always @(negedge clk) begin
    logic [12:0] we;
    logic [7:0]  re;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (bus.wr_ready) check_val("wr_mirror", 32'(bus.mem_wr), 32'(bus.wr_valid));
      if (bus.mem_wr) begin
        check_val("wr_expected", 32'(wq.size() != 0), 32'd1);
        if (wq.size() != 0) begin
          we = wq.pop_front();
          check_val("wr_addr", 32'(bus.mem_addr), 32'(we[12:8]));
          check_val("wr_data", 32'(bus.mem_wdata), 32'(we[7:0]));
        end
      end
      if (prev_stall) begin
        check_val("stall_valid", 32'(bus.rd_valid), 32'd1);
        check_val("stall_data", 32'(bus.rd_data), 32'(prev_data));
      end
      if (bus.rd_valid && bus.rd_ready) begin
        check_val("rd_expected", 32'(rq.size() != 0), 32'd1);
        if (rq.size() != 0) begin
          re = rq.pop_front();
          check_val("rd_data", 32'(bus.rd_data), 32'(re));
        end
      end
      prev_stall = bus.rd_valid && !bus.rd_ready;
      prev_data  = bus.rd_data;
      if (done) done_cnt++;
      if (dut.r_inflight && (dut.w_fifo_count == 2'd2) && !(bus.rd_valid && bus.rd_ready))
        ovf_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic w, input logic [4:0] a, input logic [4:0] l);
    int g;
    g = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_len   = l;
    while (!bus.cmd_ready && g < 100) begin
      tick();
      g++;
    end
    check_val("cmd_ready", 32'(bus.cmd_ready), 32'd1);
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'($urandom);
    bus.cmd_addr  = 5'($urandom);
    bus.cmd_len   = 5'($urandom);
  endtask

  task automatic do_write(input logic [4:0] a, input int n, input bit toggle);
    int beat, g, d0;
    bit ph;
    logic [4:0] ad;
    beat = 0; g = 0; ph = 1'b0; d0 = done_cnt;
    send_cmd(1'b1, a, 5'(n - 1));
    while (beat < n && g < 200) begin
      bus.wr_valid = toggle ? !ph : 1'b1;
      bus.wr_data  = wbuf[beat];
      ph = !ph;
      if (bus.wr_valid && bus.wr_ready) begin
        ad = 5'(int'(a) + beat);
        wq.push_back({ad, wbuf[beat]});
        ref_mem[ad] = wbuf[beat];
        beat++;
      end
      tick();
      g++;
    end
    bus.wr_valid = 1'b0;
    check_val("wr_done_pulse", 32'(done), 32'd1);
    check_val("wr_busy_after", 32'(busy), 32'd0);
    tick();
    check_val("wr_done_once", 32'(done_cnt - d0), 32'd1);
    $display("txn write addr=%0d beats=%0d accepted=%0d", a, n, beat);
  endtask

  task automatic do_read(input logic [4:0] a, input int n, input int st_lo, input int st_hi);
    int k, lat, d0;
    k = 0; lat = -1; d0 = done_cnt;
    for (int i = 0; i < n; i++) rq.push_back(ref_mem[5'(int'(a) + i)]);
    send_cmd(1'b0, a, 5'(n - 1));
    while ((rq.size() != 0 || busy) && k < 400) begin
      bus.rd_ready = !(k >= st_lo && k <= st_hi);
      if (lat < 0 && bus.rd_valid) lat = k;
      tick();
      k++;
    end
    bus.rd_ready = 1'b1;
    check_val("rd_in_time", 32'(k < 400), 32'd1);
    tick();
    check_val("rd_latency", 32'(lat), 32'd2);
    check_val("rd_all_out", 32'(rq.size()), 32'd0);
    check_val("rd_done_once", 32'(done_cnt - d0), 32'd1);
    check_val("rd_busy_after", 32'(busy), 32'd0);
    $display("txn read addr=%0d beats=%0d cycles=%0d", a, n, k);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    rst = 1'b1;
    mem_init = 1'b1;
    prev_stall = 1'b0;
    prev_data = '0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;
    bus.rd_ready  = 1'b1;
    for (int i = 0; i < 32; i++) ref_mem[i] = 8'(i * 37 + 11);
    repeat (3) tick();
    rst = 1'b0;
    mem_init = 1'b0;

    check_val("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check_val("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
    check_val("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    check_val("rst_mem_wr", 32'(bus.mem_wr), 32'd0);
    check_val("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    tick();

    for (int i = 0; i < 4; i++) wbuf[i] = 8'(8'hA0 + i);
    do_write(5'd3, 4, 1'b0);

    for (int i = 0; i < 4; i++) wbuf[i] = 8'(8'hC0 + i);
    do_write(5'd30, 4, 1'b0);
    do_read(5'd30, 4, 100, 100);

    do_read(5'd3, 8, 2, 6);

    wbuf[0] = 8'h5A;
    wbuf[1] = 8'hA5;
    do_write(5'd12, 2, 1'b1);

    // Abort a 16-beat read part-way through
    d0 = done_cnt;
    bus.rd_ready = 1'b0;
    send_cmd(1'b0, 5'd0, 5'd15);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("abort_busy", 32'(busy), 32'd0);
    check_val("abort_rd_valid", 32'(bus.rd_valid), 32'd0);
    check_val("abort_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    tick();
    tick();
    check_val("abort_no_done", 32'(done_cnt - d0), 32'd0);
    bus.rd_ready = 1'b1;
    $display("txn read addr=0 beats=16 aborted by reset");

    do_read(5'd12, 1, 100, 100);

`ifdef MEM_BURST_CSUM_EN
    wbuf[0] = 8'h12;
    wbuf[1] = 8'h34;
    wbuf[2] = 8'h56;
    do_write(5'd8, 3, 1'b0);
    check_val("csum_write", 32'(csum), 32'h70);
    do_read(5'd8, 3, 100, 100);
    check_val("csum_read", 32'(csum), 32'h70);
`endif

    check_val("wr_all_seen", 32'(wq.size()), 32'd0);
    check_val("fifo_no_overflow", 32'(ovf_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
